vid_pattern_gen: RTL and testbench

VID_PATTERN_GEN -- requirements
Module: vid_pattern_gen

---
 rtl/vid_pattern_gen.sv | 124 ++++++++++++
 tb/tb_vid_pattern_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vid_pattern_gen.sv
// rtl/vid_pattern_gen.sv - raster timing generator with gray test patterns
// Counters run active/front-porch/sync/back-porch from zero; outputs are registered one clock behind them.
module vid_pattern_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic [7:0] level,
    output logic       hs,
    output logic       vs,
    output logic       de,
    output logic [7:0] oGray,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [1:0]    mode_q;
    logic [7:0]    level_q;

    logic          frame_origin;
    logic [1:0]    mode_eff;
    logic [7:0]    level_eff;
    logic [7:0]    h_lo;
    logic [7:0]    v_lo;
    logic          de_c;
    logic          hs_c;
    logic          vs_c;
    logic [7:0]    gray_c;

    // At the frame origin the shadow is being loaded this same edge, so the
    // first pixel of a frame already uses the freshly sampled mode/level.
    always_comb begin
        frame_origin = (h_cnt == '0) && (v_cnt == '0);
        mode_eff     = frame_origin ? mode  : mode_q;
        level_eff    = frame_origin ? level : level_q;
        h_lo         = 8'(h_cnt);
        v_lo         = 8'(v_cnt);
        de_c         = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hs_c         = (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E);
        vs_c         = (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E);
        gray_c       = 8'h00;
        if (de_c) begin
            case (mode_eff)
                2'd0:    gray_c = h_lo;
                2'd1:    gray_c = v_lo;
                2'd2:    gray_c = (h_lo[5] ^ v_lo[5]) ? 8'hFF : 8'h00;
                default: gray_c = level_eff;
            endcase
        end
    end

    // Disabling parks the counters at the origin so the next enable starts a fresh frame.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            mode_q  <= 2'd0;
            level_q <= 8'h00;
        end else if (en && frame_origin) begin
            mode_q  <= mode;
            level_q <= level;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            hs          <= 1'b0;
            vs          <= 1'b0;
            de          <= 1'b0;
            oGray       <= 8'h00;
            frame_start <= 1'b0;
        end else if (!en) begin
            hs          <= 1'b0;
            vs          <= 1'b0;
            de          <= 1'b0;
            oGray       <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            hs          <= hs_c;
            vs          <= vs_c;
            de          <= de_c;
            oGray       <= gray_c;
            frame_start <= frame_origin;
        end
    end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// tb/tb_vid_pattern_gen.sv - directed bench for vid_pattern_gen on a reduced raster
// Raster: 272+4+8+4 = 288 clocks per line, 40+2+3+5 = 50 lines per frame.
module tb_vid_pattern_gen;

    localparam int HA = 272, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 40,  VFP = 2, VS = 3, VBP = 5;
    localparam int HT = HA + HFP + HS + HBP;

    logic       clock = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] level;
    logic       hs;
    logic       vs;
    logic       de;
    logic [7:0] oGray;
    logic       frame_start;

    int tests  = 0;
    int failed = 0;
    int pos    = 0;

    vid_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .level       (level),
        .hs          (hs),
        .vs          (vs),
        .de          (de),
        .oGray       (oGray),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
        pos += n;
    endtask

    // pos counts enabled edges since the last restart; after edge k the outputs show counter position k-1
    task automatic seek(input int h, input int v);
        int t;
        t = v * HT + h + 1;
        if (t > pos) step(t - pos);
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        mode  = 2'd0;
        level = 8'h5A;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_de", {7'd0, de}, 8'h00);
        chk("rst_hs", {7'd0, hs}, 8'h00);
        chk("rst_vs", {7'd0, vs}, 8'h00);
        chk("rst_fs", {7'd0, frame_start}, 8'h00);
        chk("rst_gray", oGray, 8'h00);

        rst = 1'b0;
        step(3);
        chk("dis_de", {7'd0, de}, 8'h00);
        chk("dis_fs", {7'd0, frame_start}, 8'h00);

        en  = 1'b1;
        pos = 0;
        step(1);
        chk("f0_fs", {7'd0, frame_start}, 8'h01);
        chk("f0_de", {7'd0, de}, 8'h01);
        chk("f0_gray00", oGray, 8'h00);
        step(1);
        chk("f0_fs_pulse", {7'd0, frame_start}, 8'h00);
        chk("f0_gray1", oGray, 8'h01);
        seek(270, 0); chk("ramp_270", oGray, 8'd14);
        seek(271, 0); chk("de_last", {7'd0, de}, 8'h01);
        seek(272, 0); chk("de_off", {7'd0, de}, 8'h00);
        chk("gray_blank", oGray, 8'h00);
        seek(275, 0); chk("hs_pre", {7'd0, hs}, 8'h00);
        seek(276, 0); chk("hs_rise", {7'd0, hs}, 8'h01);
        seek(283, 0); chk("hs_last", {7'd0, hs}, 8'h01);
        seek(284, 0); chk("hs_fall", {7'd0, hs}, 8'h00);
        seek(0, 1);   chk("l1_fs", {7'd0, frame_start}, 8'h00);
        chk("l1_gray", oGray, 8'h00);

        seek(0, 10);
        mode = 2'd3;
        seek(100, 10); chk("midchg_ramp", oGray, 8'd100);
        seek(5, 39);   chk("midchg_ramp39", oGray, 8'd5);
        seek(0, 40);   chk("vblank_de", {7'd0, de}, 8'h00);
        seek(287, 41); chk("vs_pre", {7'd0, vs}, 8'h00);
        seek(0, 42);   chk("vs_rise", {7'd0, vs}, 8'h01);
        seek(276, 42); chk("hs_vblank", {7'd0, hs}, 8'h01);
        seek(287, 44); chk("vs_last", {7'd0, vs}, 8'h01);
        seek(0, 45);   chk("vs_fall", {7'd0, vs}, 8'h00);
        seek(287, 49); chk("f1_fs_pre", {7'd0, frame_start}, 8'h00);
        seek(0, 50);   chk("f1_fs", {7'd0, frame_start}, 8'h01);
        chk("f1_level", oGray, 8'h5A);
        seek(280, 50); chk("lvl_blank", oGray, 8'h00);
        seek(10, 51);  chk("lvl_active", oGray, 8'h5A);

        seek(0, 70);
        mode = 2'd2;
        en   = 1'b0;
        step(1);
        chk("off_de", {7'd0, de}, 8'h00);
        chk("off_gray", oGray, 8'h00);
        step(49);
        chk("off_fs", {7'd0, frame_start}, 8'h00);
        chk("off_hs", {7'd0, hs}, 8'h00);

        en  = 1'b1;
        pos = 0;
        step(1);
        chk("re_fs", {7'd0, frame_start}, 8'h01);
        chk("chk_0_0", oGray, 8'h00);
        mode = 2'd1;
        seek(32, 0);   chk("chk_32_0", oGray, 8'hFF);
        seek(0, 32);   chk("chk_0_32", oGray, 8'hFF);
        seek(32, 32);  chk("chk_32_32", oGray, 8'h00);
        seek(287, 41); chk("re_vs_pre", {7'd0, vs}, 8'h00);
        seek(0, 42);   chk("re_vs_rise", {7'd0, vs}, 8'h01);
        seek(0, 50);   chk("f2_fs", {7'd0, frame_start}, 8'h01);
        seek(0, 85);   chk("vramp_35_a", oGray, 8'd35);
        seek(200, 85); chk("vramp_35_b", oGray, 8'd35);
        seek(100, 86); chk("vramp_36", oGray, 8'd36);

        rst  = 1'b1;
        mode = 2'd0;
        #1;
        chk("arst_de", {7'd0, de}, 8'h00);
        chk("arst_gray", oGray, 8'h00);
        chk("arst_fs", {7'd0, frame_start}, 8'h00);
        repeat (3) @(posedge clock);
        #1;
        rst = 1'b0;
        pos = 0;
        step(1);
        chk("post_fs", {7'd0, frame_start}, 8'h01);
        chk("post_gray", oGray, 8'h00);
        seek(77, 0);   chk("post_ramp", oGray, 8'd77);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
